// File: rtl/ex_mem_pkg.sv
// Shared widths and constants for the EX/MEM pipeline register.
// Also defines the bundle of values that the register hands to MEM.
package ex_mem_pkg;

    localparam int RegDataBus = 32;
    localparam int RegAddrBus = 5;

    localparam logic RstEnable    = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegDataBus-1:0]   ZeroWord  = '0;
    localparam logic [2*RegDataBus-1:0] ZeroDword = '0;

    typedef struct packed {
        logic                  wreg;
        logic [RegAddrBus-1:0] waddr;
        logic [RegDataBus-1:0] wdata;
        logic                  whilo;
        logic [RegDataBus-1:0] hi;
        logic [RegDataBus-1:0] lo;
    } mem_bundle_t;

    // A bubble carries no GPR or HI/LO write, so later forwarding logic ignores it.
    localparam mem_bundle_t MemBubble = '{
        wreg:  WriteDisable,
        waddr: '0,
        wdata: ZeroWord,
        whilo: WriteDisable,
        hi:    ZeroWord,
        lo:    ZeroWord
    };

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register.
// It also returns the multi-cycle madd/msub state to EX while EX is stalled.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    ex_stall_i,
    input  logic                    mem_stall_i,
    input  logic                    ex_wreg_i,
    input  logic [RegAddrBus-1:0]   ex_waddr_i,
    input  logic [RegDataBus-1:0]   ex_wdata_i,
    input  logic                    ex_whilo_i,
    input  logic [RegDataBus-1:0]   ex_hi_i,
    input  logic [RegDataBus-1:0]   ex_lo_i,
    input  logic [2*RegDataBus-1:0] hilo_temp_i,
    input  logic [1:0]              cnt_i,
    output logic                    mem_wreg_o,
    output logic [RegAddrBus-1:0]   mem_waddr_o,
    output logic [RegDataBus-1:0]   mem_wdata_o,
    output logic                    mem_whilo_o,
    output logic [RegDataBus-1:0]   mem_hi_o,
    output logic [RegDataBus-1:0]   mem_lo_o,
    output logic [2*RegDataBus-1:0] hilo_temp_o,
    output logic [1:0]              cnt_o
);

    mem_bundle_t mem_q;
    mem_bundle_t ex_bundle;

    assign ex_bundle = '{
        wreg:  ex_wreg_i,
        waddr: ex_waddr_i,
        wdata: ex_wdata_i,
        whilo: ex_whilo_i,
        hi:    ex_hi_i,
        lo:    ex_lo_i
    };

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            mem_q       <= MemBubble;
            hilo_temp_o <= ZeroDword;
            cnt_o       <= 2'b00;
        end else if (flush_i) begin
            mem_q       <= MemBubble;
            hilo_temp_o <= ZeroDword;
            cnt_o       <= 2'b00;
        end else if (mem_stall_i) begin
            mem_q       <= mem_q;
            hilo_temp_o <= hilo_temp_o;
            cnt_o       <= cnt_o;
        end else if (ex_stall_i) begin
            // EX keeps iterating: park its partial result here and send MEM a bubble.
            mem_q       <= MemBubble;
            hilo_temp_o <= hilo_temp_i;
            cnt_o       <= cnt_i;
        end else begin
            mem_q       <= ex_bundle;
            hilo_temp_o <= ZeroDword;
            cnt_o       <= 2'b00;
        end
    end

    assign mem_wreg_o  = mem_q.wreg;
    assign mem_waddr_o = mem_q.waddr;
    assign mem_wdata_o = mem_q.wdata;
    assign mem_whilo_o = mem_q.whilo;
    assign mem_hi_o    = mem_q.hi;
    assign mem_lo_o    = mem_q.lo;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized traffic
// compared against a priority-rule reference model.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, ex_stall_i, mem_stall_i;
    logic        ex_wreg_i, ex_whilo_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i, ex_hi_i, ex_lo_i;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic        mem_wreg_o, mem_whilo_o;
    logic [4:0]  mem_waddr_o;
    logic [31:0] mem_wdata_o, mem_hi_o, mem_lo_o;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;

    int errors = 0;
    int checks = 0;

    // Expected register contents.
    logic        e_wreg, e_whilo;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_hi, e_lo;
    logic [63:0] e_temp;
    logic [1:0]  e_cnt;

    always #5 clk = ~clk;

    ex_mem dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .ex_stall_i  (ex_stall_i),
        .mem_stall_i (mem_stall_i),
        .ex_wreg_i   (ex_wreg_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_whilo_i  (ex_whilo_i),
        .ex_hi_i     (ex_hi_i),
        .ex_lo_i     (ex_lo_i),
        .hilo_temp_i (hilo_temp_i),
        .cnt_i       (cnt_i),
        .mem_wreg_o  (mem_wreg_o),
        .mem_waddr_o (mem_waddr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_whilo_o (mem_whilo_o),
        .mem_hi_o    (mem_hi_o),
        .mem_lo_o    (mem_lo_o),
        .hilo_temp_o (hilo_temp_o),
        .cnt_o       (cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the register should hold after one edge, by priority rule.
    task automatic model_edge();
        if (!rst || flush_i) begin
            {e_wreg, e_waddr, e_wdata, e_whilo, e_hi, e_lo, e_temp, e_cnt} = '0;
        end else if (mem_stall_i) begin
            // everything holds
        end else if (ex_stall_i) begin
            {e_wreg, e_waddr, e_wdata, e_whilo, e_hi, e_lo} = '0;
            e_temp = hilo_temp_i;
            e_cnt  = cnt_i;
        end else begin
            e_wreg  = ex_wreg_i;
            e_waddr = ex_waddr_i;
            e_wdata = ex_wdata_i;
            e_whilo = ex_whilo_i;
            e_hi    = ex_hi_i;
            e_lo    = ex_lo_i;
            e_temp  = 64'd0;
            e_cnt   = 2'd0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wreg"},  64'(mem_wreg_o),  64'(e_wreg));
        check({tag, ".waddr"}, 64'(mem_waddr_o), 64'(e_waddr));
        check({tag, ".wdata"}, 64'(mem_wdata_o), 64'(e_wdata));
        check({tag, ".whilo"}, 64'(mem_whilo_o), 64'(e_whilo));
        check({tag, ".hi"},    64'(mem_hi_o),    64'(e_hi));
        check({tag, ".lo"},    64'(mem_lo_o),    64'(e_lo));
        check({tag, ".temp"},  hilo_temp_o,      e_temp);
        check({tag, ".cnt"},   64'(cnt_o),       64'(e_cnt));
    endtask

    // Apply the current inputs on one rising edge, then compare #1 later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic randomize_ex();
        ex_wreg_i   = 1'($urandom);
        ex_waddr_i  = 5'($urandom);
        ex_wdata_i  = $urandom;
        ex_whilo_i  = 1'($urandom);
        ex_hi_i     = $urandom;
        ex_lo_i     = $urandom;
        hilo_temp_i = {$urandom, $urandom};
        cnt_i       = 2'($urandom);
    endtask

    task automatic idle_ctrl();
        rst = 1'b1; flush_i = 1'b0; ex_stall_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b1; ex_stall_i = 1'b1; mem_stall_i = 1'b1;
        randomize_ex();
        {e_wreg, e_waddr, e_wdata, e_whilo, e_hi, e_lo, e_temp, e_cnt} = '0;
        #2;
        cycle("reset");
        cycle("reset2");

        // Plain advance.
        idle_ctrl();
        randomize_ex();
        ex_wreg_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h1234_5678;
        cycle("advance");
        check("advance.wdata_const", 64'(mem_wdata_o), 64'h1234_5678);

        // EX-only stall captures multi-cycle state.
        ex_stall_i = 1'b1; ex_wreg_i = 1'b1;
        hilo_temp_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'b01;
        cycle("ex_stall");
        check("ex_stall.temp_const", hilo_temp_o, 64'h0000_0001_FFFF_FFFE);
        check("ex_stall.wreg_const", 64'(mem_wreg_o), 64'd0);

        // MEM stall holds for three cycles while EX inputs churn.
        idle_ctrl();
        randomize_ex();
        ex_wdata_i = 32'hA5A5_A5A5;
        cycle("load_a5");
        mem_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_ex();
            ex_stall_i = 1'($urandom);
            cycle("mem_stall");
            check("mem_stall.wdata_const", 64'(mem_wdata_o), 64'hA5A5_A5A5);
        end

        // Flush beats a MEM stall holding a HI/LO write.
        idle_ctrl();
        randomize_ex();
        ex_whilo_i = 1'b1; ex_hi_i = 32'hDEAD_BEEF;
        cycle("load_hilo");
        flush_i = 1'b1; mem_stall_i = 1'b1;
        cycle("flush_stall");
        check("flush_stall.hi_const", 64'(mem_hi_o), 64'd0);

        // Reset abandons a multi-cycle op.
        idle_ctrl();
        ex_stall_i = 1'b1; cnt_i = 2'b01; hilo_temp_i = 64'h1234_0000_0000_5678;
        cycle("op_start");
        rst = 1'b0;
        cycle("reset_mid_op");
        check("reset_mid_op.cnt_const", 64'(cnt_o), 64'd0);

        // HI/LO pass-through.
        idle_ctrl();
        randomize_ex();
        ex_whilo_i = 1'b1; ex_hi_i = 32'h0000_00FF; ex_lo_i = 32'hFF00_0000;
        cycle("hilo_pass");
        check("hilo_pass.lo_const", 64'(mem_lo_o), 64'hFF00_0000);

        // Back-to-back ex stalls keep the last capture; a following mem stall keeps it too.
        idle_ctrl();
        ex_stall_i = 1'b1; randomize_ex();
        cycle("b2b_stall1");
        mem_stall_i = 1'b1; randomize_ex();
        cycle("b2b_stall2");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            randomize_ex();
            rst         = ($urandom_range(0, 29) != 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            mem_stall_i = ($urandom_range(0, 3) == 0);
            ex_stall_i  = ($urandom_range(0, 2) == 0);
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
